// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte frame and writes big-endian words into instruction memory.
// The core is released through cpu_run once the XOR checksum of the payload matches.
module imem_loader #(
  parameter logic [31:0] ADDR_BASE = 32'h0040_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        start,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_run,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] word_count
);

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q;
  logic [15:0] len_in;
  logic [23:0] asm_q;
  logic [1:0]  byte_idx;
  logic [7:0]  csum_q;
  logic        xfer;
  logic        last_word;

  assign xfer      = rx_valid & rx_ready;
  assign len_in    = {len_q[15:8], rx_data};
  assign last_word = (byte_idx == 2'd3) && ((word_count + 16'd1) == len_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= LEN_HI;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    rx_ready = 1'b0;
    unique case (state_q)
      LEN_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) state_d = LEN_LO;
      end
      LEN_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (32'(len_in) > MAX_WORDS) state_d = ERROR;
          else if (len_in == 16'd0)    state_d = CSUM;
          else                         state_d = DATA;
        end
      end
      DATA: begin
        rx_ready = 1'b1;
        if (rx_valid && last_word) state_d = CSUM;
      end
      CSUM: begin
        rx_ready = 1'b1;
        if (rx_valid) state_d = (rx_data == csum_q) ? DONE : ERROR;
      end
      DONE, ERROR: begin
        if (start) state_d = LEN_HI;
      end
      default: state_d = LEN_HI;
    endcase
  end

  // Datapath: the strobe is registered, so it lands the cycle after the 4th byte
  // and may overlap acceptance of the next word's first byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q      <= '0;
      asm_q      <= '0;
      byte_idx   <= '0;
      csum_q     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= ADDR_BASE;
      imem_wdata <= '0;
      word_count <= '0;
      cpu_run    <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      unique case (state_q)
        LEN_HI: begin
          if (xfer) len_q[15:8] <= rx_data;
        end
        LEN_LO: begin
          if (xfer) begin
            len_q[7:0] <= rx_data;
            if (32'(len_in) > MAX_WORDS) load_error <= 1'b1;
          end
        end
        DATA: begin
          if (xfer) begin
            csum_q   <= csum_q ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= {asm_q, rx_data};
              imem_addr  <= ADDR_BASE + {14'd0, word_count, 2'b00};
              word_count <= word_count + 16'd1;
            end else begin
              asm_q <= {asm_q[15:0], rx_data};
            end
          end
        end
        CSUM: begin
          if (xfer) begin
            if (rx_data == csum_q) begin
              load_done <= 1'b1;
              cpu_run   <= 1'b1;
            end else begin
              load_error <= 1'b1;
            end
          end
        end
        DONE, ERROR: begin
          if (start) begin
            cpu_run    <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            word_count <= '0;
            byte_idx   <= '0;
            csum_q     <= '0;
            imem_addr  <= ADDR_BASE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; expected memory writes are queued as frames are sent
// and checked against each imem_we strobe.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        start;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_run;
  logic        load_done;
  logic        load_error;
  logic [15:0] word_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned strobes = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  tx_q[$];

  imem_loader #(.ADDR_BASE(BASE), .MAX_WORDS(256)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .start(start), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_run(cpu_run), .load_done(load_done),
    .load_error(load_error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      logic [63:0] e;
      strobes++;
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'(imem_we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("we_addr", imem_addr, e[63:32]);
        check("we_data", imem_wdata, e[31:0]);
      end
    end
  end

  // Drive every queued byte with rx_valid held high on consecutive cycles.
  task automatic send_all();
    while (tx_q.size() != 0) begin
      rx_data  = tx_q.pop_front();
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic queue_word(input logic [31:0] w, input int unsigned idx, inout logic [7:0] cs);
    for (int unsigned b = 0; b < 4; b++) begin
      logic [7:0] by;
      by = w[31 - 8*b -: 8];
      tx_q.push_back(by);
      cs ^= by;
    end
    exp_q.push_back({BASE + 32'(4 * idx), w});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(rx_ready), 32'd1);
    check({tag, "_run"}, 32'(cpu_run), 32'd0);
    check({tag, "_done"}, 32'(load_done), 32'd0);
    check({tag, "_err"}, 32'(load_error), 32'd0);
    check({tag, "_wc"}, 32'(word_count), 32'd0);
    check({tag, "_addr"}, imem_addr, BASE);
  endtask

  logic [7:0]  cs;
  int unsigned s0;
  logic [31:0] words[3];

  initial begin
    reset = 1'b1; rx_data = '0; rx_valid = 1'b0; start = 1'b0;
    @(posedge clk);
    #1;
    check_idle("rst");
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single word
    cs = '0;
    tx_q.push_back(8'h00); tx_q.push_back(8'h01);
    queue_word(32'h1234_5678, 0, cs);
    check("single_csum_model", 32'(cs), 32'h08);
    tx_q.push_back(cs);
    s0 = strobes;
    send_all();
    check("single_run", 32'(cpu_run), 32'd1);
    check("single_done", 32'(load_done), 32'd1);
    check("single_wc", 32'(word_count), 32'd1);
    check("single_ready", 32'(rx_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("single_strobes", strobes - s0, 32'd1);
    pulse_start();
    check_idle("start1");

    // Three words back-to-back, CSUM in the cycle right after the last strobe
    words[0] = 32'hDEAD_BEEF; words[1] = 32'h0102_0304; words[2] = 32'hA5A5_5A5A;
    cs = '0;
    tx_q.push_back(8'h00); tx_q.push_back(8'h03);
    for (int unsigned i = 0; i < 3; i++) queue_word(words[i], i, cs);
    tx_q.push_back(cs);
    s0 = strobes;
    send_all();
    check("three_run", 32'(cpu_run), 32'd1);
    check("three_wc", 32'(word_count), 32'd3);
    check("three_strobes", strobes - s0, 32'd3);
    check("three_queue", exp_q.size(), 32'd0);
    pulse_start();
    check_idle("start2");

    // Bad checksum: word still written, then ERROR
    cs = '0;
    tx_q.push_back(8'h00); tx_q.push_back(8'h01);
    queue_word(32'h1234_5678, 0, cs);
    tx_q.push_back(8'h09);
    send_all();
    check("bad_err", 32'(load_error), 32'd1);
    check("bad_run", 32'(cpu_run), 32'd0);
    check("bad_ready", 32'(rx_ready), 32'd0);
    check("bad_done", 32'(load_done), 32'd0);
    pulse_start();
    check_idle("start3");

    // Overflow: 257 words
    s0 = strobes;
    tx_q.push_back(8'h01); tx_q.push_back(8'h01);
    send_all();
    check("ovf_err", 32'(load_error), 32'd1);
    check("ovf_ready", 32'(rx_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("ovf_strobes", strobes - s0, 32'd0);
    pulse_start();
    check_idle("start4");

    // Empty frame
    tx_q.push_back(8'h00); tx_q.push_back(8'h00); tx_q.push_back(8'h00);
    send_all();
    check("empty_done", 32'(load_done), 32'd1);
    check("empty_run", 32'(cpu_run), 32'd1);
    check("empty_wc", 32'(word_count), 32'd0);

    // Ready gating while DONE
    s0 = strobes;
    for (int i = 0; i < 10; i++) begin
      rx_data  = 8'($urandom_range(0, 255));
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      check("gate_ready", 32'(rx_ready), 32'd0);
      check("gate_done", 32'(load_done), 32'd1);
      check("gate_wc", 32'(word_count), 32'd0);
    end
    rx_valid = 1'b0;
    check("gate_strobes", strobes - s0, 32'd0);
    pulse_start();
    check_idle("start5");

    // Reset mid-word after two payload bytes
    s0 = strobes;
    tx_q.push_back(8'h00); tx_q.push_back(8'h01);
    tx_q.push_back(8'hAA); tx_q.push_back(8'hBB);
    send_all();
    #2;
    reset = 1'b1;
    #1;
    check_idle("midrst");
    check("midrst_we", 32'(imem_we), 32'd0);
    check("midrst_wdata", imem_wdata, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_strobes", strobes - s0, 32'd0);
    cs = '0;
    tx_q.push_back(8'h00); tx_q.push_back(8'h01);
    queue_word(32'hCAFE_BABE, 0, cs);
    tx_q.push_back(cs);
    send_all();
    check("fresh_done", 32'(load_done), 32'd1);
    check("fresh_wc", 32'(word_count), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("final_queue", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
